// File: rtl/toysram_16x12_port_ctl.sv
// ---------------------------------------------------------------------------
// toysram_16x12_port_ctl
// Port controller for one 16x12 toysram subarray. It turns two synchronous
// read requests and one write request into registered wordline/bitline
// drive. It also senses the negative-active read bitlines and returns
// registered, true-polarity read data two cycles after the request.
//
// Optional build macro: TOYSRAM_CTL_WR_BYPASS_EN
//   When defined, a read whose sense cycle falls in the write SETUP state of
//   the same row returns the pending write data instead of the array contents.
// ---------------------------------------------------------------------------
module toysram_16x12_port_ctl #(
  parameter int unsigned WR_SETUP_CYC = 1,  // bitline setup before WWL rises (1..15)
  parameter int unsigned WR_PULSE_CYC = 1,  // WWL high time (1..15)
  parameter int unsigned WR_HOLD_CYC  = 1   // bitline hold after WWL falls (1..15)
) (
  input  logic        clk,
  input  logic        reset,
  // read port 0
  input  logic        rd0_en,
  input  logic [0:3]  rd0_addr,
  output logic        rd0_valid,
  output logic [0:11] rd0_data,
  // read port 1
  input  logic        rd1_en,
  input  logic [0:3]  rd1_addr,
  output logic        rd1_valid,
  output logic [0:11] rd1_data,
  // write port
  input  logic        wr_en,
  input  logic [0:3]  wr_addr,
  input  logic [0:11] wr_data,
  output logic        wr_ready,
  // array side
  output logic [0:15] RWL0,
  output logic [0:15] RWL1,
  output logic [0:15] WWL,
  input  logic [0:11] RBL0,
  input  logic [0:11] RBL1,
  output logic [0:11] WBL,
  output logic [0:11] WBLb
);

  // Write FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Counter reload values for each timed state
  localparam logic [3:0] SETUP_LD = 4'(WR_SETUP_CYC);
  localparam logic [3:0] PULSE_LD = 4'(WR_PULSE_CYC);
  localparam logic [3:0] HOLD_LD  = 4'(WR_HOLD_CYC);

  // Row address to one-hot wordline vector (bit index == row number)
  function automatic logic [0:15] one_hot(input logic [0:3] a);
    logic [0:15] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Read-port state, indexed by port number
  logic [1:0]  rd_en_v;
  logic [0:3]  rd_addr_v [2];
  logic [0:11] rbl_v     [2];
  logic [0:15] rwl_q     [2];
  logic [1:0]  rd_valid_q;
  logic [0:11] rd_data_q [2];
  logic [0:11] rd_sense  [2];

  // Write-port state
  logic [1:0]  wr_state;
  logic [3:0]  wr_cnt;
  logic [0:3]  wr_addr_q;

  assign rd_en_v      = {rd1_en, rd0_en};
  assign rd_addr_v[0] = rd0_addr;
  assign rd_addr_v[1] = rd1_addr;
  assign rbl_v[0]     = RBL0;
  assign rbl_v[1]     = RBL1;

  assign RWL0      = rwl_q[0];
  assign RWL1      = rwl_q[1];
  assign rd0_valid = rd_valid_q[0];
  assign rd1_valid = rd_valid_q[1];
  assign rd0_data  = rd_data_q[0];
  assign rd1_data  = rd_data_q[1];
  assign wr_ready  = (wr_state == ST_IDLE);

  // Sense value per port: inverted bitlines, or pending write data on a bypass hit
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // NOTE: assign a default before any conditional override so no latch is inferred.
      rd_sense[p] = ~rbl_v[p];
`ifdef TOYSRAM_CTL_WR_BYPASS_EN
      // rwl_q is one-hot when active, so equality means "same row, read in C1".
      // WBL carries the latched write data throughout SETUP.
      if (wr_state == ST_SETUP && rwl_q[p] == one_hot(wr_addr_q))
        rd_sense[p] = WBL;
`endif
    end
  end

  // Read pipeline: C0 request -> C1 wordline pulse -> C2 data valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        rwl_q[p]     <= '0;
        rd_data_q[p] <= '0;
      end
      rd_valid_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        // NOTE: non-blocking assignments keep every stage reading last cycle's value.
        rwl_q[p]      <= rd_en_v[p] ? one_hot(rd_addr_v[p]) : '0;
        rd_valid_q[p] <= |rwl_q[p];
        if (|rwl_q[p])
          rd_data_q[p] <= rd_sense[p];
      end
    end
  end

  // Write sequencer: IDLE -> SETUP -> PULSE -> HOLD -> IDLE, bitlines/wordlines from flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state  <= ST_IDLE;
      wr_cnt    <= '0;
      wr_addr_q <= '0;
      WWL       <= '0;
      WBL       <= '0;
      WBLb      <= '1;
    end else begin
      case (wr_state)
        ST_IDLE: begin
          // Requests while busy are simply not seen; only IDLE samples wr_en.
          if (wr_en) begin
            wr_addr_q <= wr_addr;
            WBL       <= wr_data;
            WBLb      <= ~wr_data;
            wr_cnt    <= SETUP_LD;
            wr_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (wr_cnt == 4'd1) begin
            WWL      <= one_hot(wr_addr_q);
            wr_cnt   <= PULSE_LD;
            wr_state <= ST_PULSE;
          end else begin
            wr_cnt <= wr_cnt - 4'd1;
          end
        end
        ST_PULSE: begin
          if (wr_cnt == 4'd1) begin
            WWL      <= '0;
            wr_cnt   <= HOLD_LD;
            wr_state <= ST_HOLD;
          end else begin
            wr_cnt <= wr_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (wr_cnt == 4'd1) begin
            WBL      <= '0;
            WBLb     <= '1;
            wr_cnt   <= '0;
            wr_state <= ST_IDLE;
          end else begin
            wr_cnt <= wr_cnt - 4'd1;
          end
        end
        default: begin
          WWL      <= '0;
          wr_cnt   <= '0;
          wr_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toysram_16x12_port_ctl.sv
// ---------------------------------------------------------------------------
// Directed bench for toysram_16x12_port_ctl.
// u_dut   : default timing, attached to a behavioural 16x12 array model
// u_dut_b : setup/pulse/hold = 3/2/2, bitline/wordline timing only
// u_dut_c : pulse = 4, used for reset-in-PULSE
// Honours TOYSRAM_CTL_WR_BYPASS_EN for the collision expectations.
// ---------------------------------------------------------------------------
module tb_toysram_16x12_port_ctl;

  logic        clk;
  logic        reset;
  logic        rd0_en, rd1_en, wr_en, wr_en_b, wr_en_c;
  logic [0:3]  rd0_addr, rd1_addr, wr_addr;
  logic [0:11] wr_data;
  logic        rd0_valid, rd1_valid, wr_ready;
  logic [0:11] rd0_data, rd1_data;
  logic [0:15] RWL0, RWL1, WWL;
  logic [0:11] RBL0, RBL1, WBL, WBLb;

  // secondary instances
  logic        tie_lo;
  logic [0:3]  tie_addr;
  logic [0:11] tie_rbl;
  logic        b_rd0_valid, b_rd1_valid, b_wr_ready;
  logic [0:11] b_rd0_data, b_rd1_data, b_WBL, b_WBLb;
  logic [0:15] b_RWL0, b_RWL1, b_WWL;
  logic        c_rd0_valid, c_rd1_valid, c_wr_ready;
  logic [0:11] c_rd0_data, c_rd1_data, c_WBL, c_WBLb;
  logic [0:15] c_RWL0, c_RWL1, c_WWL;

  int vectors     = 0;
  int miscompares = 0;

  toysram_16x12_port_ctl u_dut (
    .clk(clk), .reset(reset),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .RWL0(RWL0), .RWL1(RWL1), .WWL(WWL), .RBL0(RBL0), .RBL1(RBL1),
    .WBL(WBL), .WBLb(WBLb)
  );

  toysram_16x12_port_ctl #(.WR_SETUP_CYC(3), .WR_PULSE_CYC(2), .WR_HOLD_CYC(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .rd0_en(tie_lo), .rd0_addr(tie_addr), .rd0_valid(b_rd0_valid), .rd0_data(b_rd0_data),
    .rd1_en(tie_lo), .rd1_addr(tie_addr), .rd1_valid(b_rd1_valid), .rd1_data(b_rd1_data),
    .wr_en(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(b_wr_ready),
    .RWL0(b_RWL0), .RWL1(b_RWL1), .WWL(b_WWL), .RBL0(tie_rbl), .RBL1(tie_rbl),
    .WBL(b_WBL), .WBLb(b_WBLb)
  );

  toysram_16x12_port_ctl #(.WR_SETUP_CYC(1), .WR_PULSE_CYC(4), .WR_HOLD_CYC(1)) u_dut_c (
    .clk(clk), .reset(reset),
    .rd0_en(tie_lo), .rd0_addr(tie_addr), .rd0_valid(c_rd0_valid), .rd0_data(c_rd0_data),
    .rd1_en(tie_lo), .rd1_addr(tie_addr), .rd1_valid(c_rd1_valid), .rd1_data(c_rd1_data),
    .wr_en(wr_en_c), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(c_wr_ready),
    .RWL0(c_RWL0), .RWL1(c_RWL1), .WWL(c_WWL), .RBL0(tie_rbl), .RBL1(tie_rbl),
    .WBL(c_WBL), .WBLb(c_WBLb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural array: capture WBL on each WWL rising edge, dot-AND read bitlines
  logic [0:11] mem [16];
  logic [0:15] wwl_prev;

  initial begin
    for (int r = 0; r < 16; r++) mem[r] = '0;
    wwl_prev = '0;
  end

  always @(WWL) begin
    for (int r = 0; r < 16; r++)
      if (WWL[r] && !wwl_prev[r]) mem[r] = WBL;
    wwl_prev = WWL;
  end

  always_comb begin
    RBL0 = '1;
    RBL1 = '1;
    for (int r = 0; r < 16; r++) begin
      if (RWL0[r]) RBL0 = RBL0 & ~mem[r];
      if (RWL1[r]) RBL1 = RBL1 & ~mem[r];
    end
  end

  function automatic logic [0:15] one_hot(input int a);
    logic [0:15] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  logic [5:0]  rdy_pat;
  logic [0:11] exp_first;

  initial begin
    reset = 1'b0;
    rd0_en = 1'b0; rd1_en = 1'b0; wr_en = 1'b0; wr_en_b = 1'b0; wr_en_c = 1'b0;
    rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
    tie_lo = 1'b0; tie_addr = '0; tie_rbl = '1;
    #1 reset = 1'b1;

    // ---------------- reset state ----------------
    tick();
    check("rst_rwl0", RWL0, 16'h0000);
    check("rst_rwl1", RWL1, 16'h0000);
    check("rst_wwl", WWL, 16'h0000);
    check("rst_wbl", WBL, 12'h000);
    check("rst_wblb", WBLb, 12'hFFF);
    check("rst_rd0_valid", rd0_valid, 0);
    check("rst_rd1_valid", rd1_valid, 0);
    check("rst_rd0_data", rd0_data, 12'h000);
    check("rst_rd1_data", rd1_data, 12'h000);
    check("rst_wr_ready", wr_ready, 1);
    reset = 1'b0;
    tick();

    // ---------------- single write row 5 = A5C, then read ----------------
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 12'hA5C;
    tick(); wr_en = 1'b0;
    check("w5_setup_ready", wr_ready, 0);
    check("w5_setup_wbl", WBL, 12'hA5C);
    check("w5_setup_wblb", WBLb, 12'h5A3);
    check("w5_setup_wwl", WWL, 16'h0000);
    tick();
    check("w5_pulse_wwl", WWL, one_hot(5));
    check("w5_pulse_wbl", WBL, 12'hA5C);
    tick();
    check("w5_hold_wwl", WWL, 16'h0000);
    check("w5_hold_wblb", WBLb, 12'h5A3);
    tick();
    check("w5_idle_ready", wr_ready, 1);
    check("w5_idle_wbl", WBL, 12'h000);
    check("w5_idle_wblb", WBLb, 12'hFFF);
    rd0_en = 1'b1; rd0_addr = 4'd5;
    tick(); rd0_en = 1'b0;
    check("r5_c1_rwl0", RWL0, one_hot(5));
    check("r5_c1_valid", rd0_valid, 0);
    tick();
    check("r5_c2_valid", rd0_valid, 1);
    check("r5_c2_data", rd0_data, 12'hA5C);
    check("r5_c2_rwl0", RWL0, 16'h0000);
    tick();
    check("r5_c3_valid", rd0_valid, 0);
    check("r5_c3_hold", rd0_data, 12'hA5C);

    // ---------------- fill rows with r*0x111 ----------------
    for (int r = 0; r < 16; r++) begin
      check($sformatf("fill_ready_%0d", r), wr_ready, 1);
      wr_en = 1'b1; wr_addr = 4'(r); wr_data = 12'(r * 'h111);
      tick(); wr_en = 1'b0;
      tick(); tick(); tick();
    end

    // ---------------- streamed reads, rd0 up / rd1 down ----------------
    for (int k = 0; k < 18; k++) begin
      if (k >= 1 && k <= 16) begin
        check($sformatf("strm_rwl0_%0d", k), RWL0, one_hot(k - 1));
        check($sformatf("strm_rwl1_%0d", k), RWL1, one_hot(16 - k));
      end
      if (k >= 2) begin
        check($sformatf("strm_v0_%0d", k), rd0_valid, 1);
        check($sformatf("strm_d0_%0d", k), rd0_data, 12'((k - 2) * 'h111));
        check($sformatf("strm_v1_%0d", k), rd1_valid, 1);
        check($sformatf("strm_d1_%0d", k), rd1_data, 12'((17 - k) * 'h111));
      end
      if (k < 16) begin
        rd0_en = 1'b1; rd0_addr = 4'(k);
        rd1_en = 1'b1; rd1_addr = 4'(15 - k);
      end else begin
        rd0_en = 1'b0; rd1_en = 1'b0;
      end
      tick();
    end
    check("strm_end_v0", rd0_valid, 0);
    check("strm_end_v1", rd1_valid, 0);
    check("strm_end_rwl0", RWL0, 16'h0000);

    // ---------------- wr_en held 6 cycles ----------------
    rdy_pat = 6'b100010;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 12'h123;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin wr_addr = 4'd9;  wr_data = 12'h0F0; end
      if (c == 4) begin wr_addr = 4'd8;  wr_data = 12'h456; end
      if (c == 5) begin wr_addr = 4'd10; wr_data = 12'h00F; end
      check($sformatf("held_ready_%0d", c), wr_ready, rdy_pat[5 - c]);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick();
    check("held_done_ready", wr_ready, 1);
    rd0_en = 1'b1; rd0_addr = 4'd7; rd1_en = 1'b1; rd1_addr = 4'd8;
    tick();
    rd0_addr = 4'd9; rd1_addr = 4'd10;
    tick();
    rd0_en = 1'b0; rd1_en = 1'b0;
    check("held_row7", rd0_data, 12'h123);
    check("held_row8", rd1_data, 12'h456);
    tick();
    check("held_row9_untouched", rd0_data, 12'h999);
    check("held_row10_untouched", rd1_data, 12'hAAA);

    // both ports, same row, same cycle
    rd0_en = 1'b1; rd0_addr = 4'd12; rd1_en = 1'b1; rd1_addr = 4'd12;
    tick(); rd0_en = 1'b0; rd1_en = 1'b0;
    tick();
    check("same_row_d0", rd0_data, 12'hCCC);
    check("same_row_d1", rd1_data, 12'hCCC);
    check("same_row_v1", rd1_valid, 1);

    // ---------------- read/write collision on row 3 ----------------
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 12'h000;
    tick(); wr_en = 1'b0;
    tick(); tick(); tick();
`ifdef TOYSRAM_CTL_WR_BYPASS_EN
    exp_first = 12'hFFF;
`else
    exp_first = 12'h000;
`endif
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 12'hFFF;
    rd1_en = 1'b1; rd1_addr = 4'd3;
    rd0_en = 1'b1; rd0_addr = 4'd4;
    tick(); wr_en = 1'b0;
    check("col_setup_rwl1", RWL1, one_hot(3));
    check("col_setup_wbl", WBL, 12'hFFF);
    check("col_setup_wwl", WWL, 16'h0000);
    tick(); rd0_en = 1'b0; rd1_en = 1'b0;
    check("col_pulse_wwl", WWL, one_hot(3));
    check("col_pulse_rwl1", RWL1, one_hot(3));
    check("col_first_valid", rd1_valid, 1);
    check("col_first_data", rd1_data, exp_first);
    check("col_other_row_a", rd0_data, 12'h444);
    tick();
    check("col_second_valid", rd1_valid, 1);
    check("col_second_data", rd1_data, 12'hFFF);
    check("col_other_row_b", rd0_data, 12'h444);
    tick();

    // ---------------- async reset during PULSE and read C1 ----------------
    wr_en_c = 1'b1; wr_addr = 4'd6; wr_data = 12'h5A5;
    tick(); wr_en_c = 1'b0;
    tick();
    check("rstp_c_pulse_wwl", c_WWL, one_hot(6));
    rd0_en = 1'b1; rd0_addr = 4'd2;
    tick(); rd0_en = 1'b0;
    check("rstp_c1_rwl0", RWL0, one_hot(2));
    check("rstp_c_still_pulse", c_WWL, one_hot(6));
    #2 reset = 1'b1;
    #1;
    check("rstp_async_rwl0", RWL0, 16'h0000);
    check("rstp_async_wwl", c_WWL, 16'h0000);
    check("rstp_async_wbl", c_WBL, 12'h000);
    check("rstp_async_wblb", c_WBLb, 12'hFFF);
    tick();
    reset = 1'b0;
    tick();
    check("rstp_no_valid", rd0_valid, 0);
    check("rstp_data_cleared", rd0_data, 12'h000);
    check("rstp_ready", c_wr_ready, 1);
    check("rstp_wwl_low", c_WWL, 16'h0000);
    tick();
    check("rstp_no_valid_late", rd0_valid, 0);

    // ---------------- custom timing 3/2/2 ----------------
    wr_en_b = 1'b1; wr_addr = 4'd1; wr_data = 12'h3C3;
    tick(); wr_en_b = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("t322_wbl_%0d", k), b_WBL, (k <= 7) ? 12'h3C3 : 12'h000);
      check($sformatf("t322_wwl_%0d", k), b_WWL, (k == 4 || k == 5) ? one_hot(1) : 16'h0000);
      check($sformatf("t322_ready_%0d", k), b_wr_ready, (k == 8) ? 1 : 0);
      if (k < 8) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
